capture_window_ctrl: RTL

- Consumes the one-cycle-registered trigger_start level from the trigger decoder.
- Opens a sample-capture window of programmable delay and length for each laser pulse, counts captured pulses, and reports completion to the host-side capture control.
- Sits between the trigger decoder and the ADC sample accumulation/FIFO stage; sample_valid gates which ADC samples are accumulated.

---
 rtl/capture_pkg.sv | 21 ++
 rtl/capture_down_counter.sv | 39 +++
 rtl/capture_window_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared state encoding and default widths for the capture window controller
//
// Purpose: common types for capture_window_ctrl and capture_down_counter.
// Contents: capture_state_e (IDLE, ARMED, DELAY, RECORD, DONE) and default widths.
// Optional feature macro used elsewhere in the bundle: CAPTURE_MISS_CNT_EN.

package capture_pkg;

  localparam int unsigned DEF_DELAY_W = 12;
  localparam int unsigned DEF_LEN_W   = 14;
  localparam int unsigned DEF_CNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    DELAY  = 3'd2,
    RECORD = 3'd3,
    DONE   = 3'd4
  } capture_state_e;

endpackage

// File: rtl/capture_down_counter.sv
// rtl/capture_down_counter.sv - loadable down-counter with zero flag
//
// Purpose: holds a count that is loaded on demand and decremented toward zero;
//          it never wraps below zero.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load_i        load load_val_i (wins over dec_i)
//   load_val_i    value to load
//   dec_i         decrement by one while non-zero
//   zero_o        count is zero

module capture_down_counter
  import capture_pkg::*;
#(
  parameter int unsigned W = DEF_DELAY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/capture_window_ctrl.sv
// rtl/capture_window_ctrl.sv - per-pulse sample-capture window sequencer
//
// Purpose: on each trigger rise opens a sample window after a programmable
//          delay, counts completed windows and flags completion of a capture.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   capture_en          host enable; low aborts to IDLE
//   trigger_start       trigger level; only its rising edge matters
//   trig_delay          clocks from trigger rise to first window sample
//   record_len          window length in clocks (0 behaves as 1)
//   pulse_num           windows per capture (0 = free-running)
//   sample_valid        high during the window
//   record_start/_end   one-cycle markers on first/last window sample
//   pulse_cnt           completed windows since capture started
//   capture_busy        high in ARMED, DELAY, RECORD
//   capture_done        sticky high in DONE
//   miss_cnt            (CAPTURE_MISS_CNT_EN only) rises ignored in DELAY/RECORD
// Optional feature macro: CAPTURE_MISS_CNT_EN

module capture_window_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned DELAY_W = DEF_DELAY_W,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture_en,
  input  logic               trigger_start,
  input  logic [DELAY_W-1:0] trig_delay,
  input  logic [LEN_W-1:0]   record_len,
  input  logic [CNT_W-1:0]   pulse_num,
  output logic               sample_valid,
  output logic               record_start,
  output logic               record_end,
  output logic [CNT_W-1:0]   pulse_cnt,
  output logic               capture_busy,
  output logic               capture_done
`ifdef CAPTURE_MISS_CNT_EN
  ,
  output logic [CNT_W-1:0]   miss_cnt
`endif
);

  capture_state_e     state_q;
  logic               trig_q;
  logic [DELAY_W-1:0] delay_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   pulse_cnt_q;
  logic [CNT_W-1:0]   pulse_cnt_d;
  logic               sample_valid_q;
  logic               record_start_q;
  logic               record_end_q;
  logic               busy_q;
  logic               done_q;

  logic               rise;
  logic               dly_load;
  logic               dly_zero;
  logic               rec_load;
  logic               rec_zero;
  logic               start_rec;
  logic               len_is_one;
  logic [DELAY_W-1:0] dly_load_val;
  logic [LEN_W-1:0]   rec_load_val;

  assign rise        = trigger_start & ~trig_q;
  assign pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
  assign len_is_one  = (len_q <= LEN_W'(1));

  // Delay counter holds the DELAY cycles still to come after the current one.
  assign dly_load     = capture_en && (state_q == ARMED) && rise && (delay_q != '0);
  assign dly_load_val = delay_q - DELAY_W'(1);

  // Window opens next cycle, either straight from ARMED or at the end of DELAY.
  assign start_rec = capture_en &&
                     (((state_q == ARMED) && rise && (delay_q == '0)) ||
                      ((state_q == DELAY) && dly_zero));

  // Record counter reaches zero on the second-to-last window cycle so that the
  // registered record_end lands exactly on the last sample. Windows of 1 flag
  // record_end at entry instead.
  assign rec_load     = start_rec;
  assign rec_load_val = len_is_one ? '0 : (len_q - LEN_W'(2));

  capture_down_counter #(.W(DELAY_W)) u_delay_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (dly_load),
    .load_val_i (dly_load_val),
    .dec_i      (state_q == DELAY),
    .zero_o     (dly_zero)
  );

  capture_down_counter #(.W(LEN_W)) u_record_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (rec_load),
    .load_val_i (rec_load_val),
    .dec_i      (state_q == RECORD),
    .zero_o     (rec_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      trig_q         <= 1'b0;
      delay_q        <= '0;
      len_q          <= '0;
      num_q          <= '0;
      pulse_cnt_q    <= '0;
      sample_valid_q <= 1'b0;
      record_start_q <= 1'b0;
      record_end_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      trig_q         <= trigger_start;
      record_start_q <= 1'b0;
      record_end_q   <= 1'b0;
      if (!capture_en) begin
        // Abort from any state; pulse_cnt is kept for the host to read.
        state_q        <= IDLE;
        sample_valid_q <= 1'b0;
        busy_q         <= 1'b0;
        done_q         <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q     <= ARMED;
            delay_q     <= trig_delay;
            len_q       <= record_len;
            num_q       <= pulse_num;
            pulse_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
          ARMED, DELAY: begin
            if ((state_q == ARMED) && rise && (delay_q != '0)) begin
              state_q <= DELAY;
            end else if (start_rec) begin
              state_q        <= RECORD;
              sample_valid_q <= 1'b1;
              record_start_q <= 1'b1;
              record_end_q   <= len_is_one;
            end
          end
          RECORD: begin
            if (record_end_q) begin
              sample_valid_q <= 1'b0;
              pulse_cnt_q    <= pulse_cnt_d;
              if ((num_q != '0) && (pulse_cnt_d == num_q)) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ARMED;
              end
            end else begin
              record_end_q <= rec_zero;
            end
          end
          DONE: begin
            state_q <= DONE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef CAPTURE_MISS_CNT_EN
  logic [CNT_W-1:0] miss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_q <= '0;
    end else if (capture_en) begin
      if (state_q == IDLE) begin
        miss_q <= '0;
      end else if (((state_q == DELAY) || (state_q == RECORD)) && rise && (miss_q != '1)) begin
        miss_q <= miss_q + CNT_W'(1);
      end
    end
  end

  assign miss_cnt = miss_q;
`endif

  assign sample_valid = sample_valid_q;
  assign record_start = record_start_q;
  assign record_end   = record_end_q;
  assign pulse_cnt    = pulse_cnt_q;
  assign capture_busy = busy_q;
  assign capture_done = done_q;

endmodule
